ring_rr_arbiter: RTL
====================

# ring_rr_arbiter

Round-robin arbiter that shares one resource between `WIDTH` requesters using a rotating one-hot priority pointer (ring token).
- The pointer advances only when a grant is released, so every active requester is served in ring order.
- Each grant is capped at `HOLD` consecutive cycles, so no requester can starve the others.
- It sits between the requesting blocks and the shared datapath; `grant` is the select for that datapath.

## Interface
- `WIDTH`, 4, number of requesters; ring pointer and grant width (≥2).
- `HOLD`, 4, maximum consecutive cycles a single grant is held (≥1).
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous, active-low.
- `en` input 1: when high, arbitration may start a new grant.
- `req` input WIDTH: request per requester; level, held high while service is wanted.
- `grant` output WIDTH: registered one-hot grant; all-zero when nothing is granted.
- `busy` output 1: high while a grant is active (state GRANT).
- `ptr` output WIDTH: one-hot ring pointer; highest-priority position for the next arbitration.
- `hold_cnt` output max(1,$clog2(HOLD)): cycles already spent in the current grant, minus one.

## Operation
- Reset values (`rst`=0): `grant`=0, `busy`=0, `ptr`=1 (bit 0), `hold_cnt`=0, state IDLE.
- Reset takes effect immediately, without waiting for a clock edge.
- States:
  - IDLE: no grant is active.
  - GRANT: exactly one bit of `grant` is set.
- IDLE, at a rising edge:
  - Requires `en`=1 and `req`≠0.
  - Winner = first set `req` bit scanning upward from the `ptr` position, wrapping from bit WIDTH-1 to bit 0.
  - Sets `grant` to the winner's one-hot value, `hold_cnt`=0, state → GRANT.
  - Otherwise all outputs hold.
- GRANT, at a rising edge:
  - Release when `req` of the granted bit is 0, or `hold_cnt`=HOLD-1.
  - On release: `grant`=0, `hold_cnt`=0, state → IDLE, `ptr` = granted bit rotated left by one (bit WIDTH-1 wraps to bit 0).
  - Otherwise: `hold_cnt` increments.
- `en` only gates new grants. Dropping `en` during GRANT does not shorten the current grant.
- `ptr` changes only on release.
- Requests from non-granted requesters during GRANT are ignored until the next IDLE arbitration.
- Simultaneous early release and hold limit on the same edge: single release, same `ptr` update.
- HOLD=1: every grant lasts exactly one cycle.

## Timing
- Request-to-grant latency: `req` sampled high in IDLE at edge k → `grant` valid after edge k.
- Maximum grant length: `grant` stays high for at most HOLD cycles.
- Early release: `grant` is still high during the cycle in which its `req` is first seen low, and drops at the next edge.
- Idle gap: at least one cycle with `grant`=0 between any two grants, including back-to-back grants to the same requester.
- Worst-case wait for a continuously requesting input: (WIDTH-1)·(HOLD+1) cycles after its request is first sampled in IDLE.
- All outputs are registered; there is no combinational path from `req` or `en` to `grant`.

## Test plan
- Reset: hold `rst`=0 with `req`=1111, `en`=1 → `grant`=0000, `busy`=0, `ptr`=0001, `hold_cnt`=0. After release, first edge → `grant`=0001.
- Single requester, WIDTH=4, HOLD=4: `req`=0100 continuously.
  - `grant`=0100 for 4 cycles (`hold_cnt` 0..3), then 0000 for 1 cycle with `ptr`=1000.
  - Then `grant`=0100 again, via wrap from 1000.
- Full load: `req`=1111.
  - `grant` sequence 0001, 0010, 0100, 1000, 0001, each granted requester held 4 cycles, one zero cycle between.
  - `ptr` steps 0010, 0100, 1000, 0001.
- Early release: `req`=0010 granted; drop `req[1]` after `hold_cnt`=1.
  - `grant` remains 0010 that cycle, is 0000 after the next edge.
  - `ptr`=0100, `hold_cnt`=0.
- Enable gating:
  - `en`=0 with `req`=1010 in IDLE for 10 cycles → `grant` stays 0000, `ptr` unchanged.
  - `en` dropped mid-grant → grant still runs all 4 cycles.
- Asynchronous reset mid-grant: assert `rst`=0 between clock edges while `grant`=1000.
  - `grant`=0000, `busy`=0, `ptr`=0001 before the next edge.
  - Resumes from `ptr`=0001 after release.

Source files
------------

// File: rtl/ring_rr_arbiter_if.sv
// rtl/ring_rr_arbiter_if.sv - request/grant bundle between requesters and the ring arbiter
interface ring_rr_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 4
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic             en;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] grant;
    logic             busy;
    logic [WIDTH-1:0] ptr;
    logic [CW-1:0]    hold_cnt;

    modport master (
        output en, req,
        input  grant, busy, ptr, hold_cnt
    );

    modport slave (
        input  en, req,
        output grant, busy, ptr, hold_cnt
    );
endinterface

// File: rtl/ring_rr_arbiter.sv
// rtl/ring_rr_arbiter.sv - round-robin arbiter with one-hot ring pointer and capped grant length
module ring_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 4
) (
    input  logic              clk,
    input  logic              rst,
    ring_rr_arbiter_if.slave  bus
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] grant_q, grant_nx;
    logic [WIDTH-1:0] ptr_q, ptr_nx;
    logic [CW-1:0]    hc_q, hc_nx;
    logic [WIDTH-1:0] masked, winner;
    logic             release_now;

    // Requests at or above the pointer win first; otherwise wrap to the lowest set request.
    always_comb begin
        masked = bus.req & ~(ptr_q - WIDTH'(1));
        if (|masked) begin
            winner = masked & (~masked + WIDTH'(1));
        end else begin
            winner = bus.req & (~bus.req + WIDTH'(1));
        end
    end

    assign release_now = !(|(bus.req & grant_q)) || (hc_q == CW'(HOLD - 1));

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        ptr_nx   = ptr_q;
        hc_nx    = hc_q;
        case (state)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    grant_nx = winner;
                    hc_nx    = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_nx = '0;
                    hc_nx    = '0;
                    ptr_nx   = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
                    state_nx = IDLE;
                end else begin
                    hc_nx = hc_q + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                hc_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr_q   <= WIDTH'(1);
            hc_q    <= '0;
        end else begin
            state   <= state_nx;
            grant_q <= grant_nx;
            ptr_q   <= ptr_nx;
            hc_q    <= hc_nx;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = (state == GRANT);
    assign bus.ptr      = ptr_q;
    assign bus.hold_cnt = hc_q;
endmodule
